// File: rtl/complex_demux_1to2_15bits.sv
// Sequential 1-to-2 complex demultiplexer for S3.11 sample streams.
// Bursts of BLOCK_LEN accepted samples alternate between lane 0 and lane 1.
// Each lane owns a one-entry output register with its own valid/ready
// handshake, so a stalled lane only blocks input while it is the target.
module complex_demux_1to2_15bits #(
    parameter int WL        = 14,
    parameter int BLOCK_LEN = 8,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync,
    input  logic signed [WL:0]   in_real,
    input  logic signed [WL:0]   in_imag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [WL:0]   out0_real,
    output logic signed [WL:0]   out0_imag,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic signed [WL:0]   out1_real,
    output logic signed [WL:0]   out1_imag,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic                 lane,
    output logic [CNT_W-1:0]     sample_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    logic lane0_free;
    logic lane1_free;
    logic accept;
    logic load0;
    logic load1;
    logic burst_end;

    // Input readiness depends only on the targeted lane having room, so the
    // other lane's backpressure never stalls the source.
    always_comb begin
        lane0_free = !out0_valid || out0_ready;
        lane1_free = !out1_valid || out1_ready;
        in_ready   = !rst && (lane ? lane1_free : lane0_free);
        accept     = in_valid && in_ready;
        load0      = accept && !lane;
        load1      = accept && lane;
        burst_end  = (sample_cnt == LAST_CNT);
    end

    // Lane 0 register: a load wins over a drain so back-to-back traffic keeps
    // valid high and the lane sustains one sample per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_real  <= '0;
            out0_imag  <= '0;
            out0_valid <= 1'b0;
        end else if (load0) begin
            out0_real  <= in_real;
            out0_imag  <= in_imag;
            out0_valid <= 1'b1;
        end else if (out0_valid && out0_ready) begin
            out0_valid <= 1'b0;
        end
    end

    // Lane 1 register, identical behaviour to lane 0 and drained independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            out1_real  <= '0;
            out1_imag  <= '0;
            out1_valid <= 1'b0;
        end else if (load1) begin
            out1_real  <= in_real;
            out1_imag  <= in_imag;
            out1_valid <= 1'b1;
        end else if (out1_valid && out1_ready) begin
            out1_valid <= 1'b0;
        end
    end

    // Burst position tracking; sync realigns to the start of a lane-0 burst
    // and overrides any advance, while a coincident sample was already routed
    // using the pre-sync lane above.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= 1'b0;
            sample_cnt <= '0;
        end else if (sync) begin
            lane       <= 1'b0;
            sample_cnt <= '0;
        end else if (accept) begin
            if (burst_end) begin
                sample_cnt <= '0;
                lane       <= !lane;
            end else begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_complex_demux_1to2_15bits.sv
// Testbench for complex_demux_1to2_15bits: directed steps plus a randomized
// phase, all compared against a stream-position model of the demultiplexer.
module tb_complex_demux_1to2_15bits;

    localparam int WL        = 14;
    localparam int BLOCK_LEN = 8;
    localparam int CNT_W     = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                sync;
    logic signed [WL:0]  in_real;
    logic signed [WL:0]  in_imag;
    logic                in_valid;
    logic                in_ready;
    logic signed [WL:0]  out0_real;
    logic signed [WL:0]  out0_imag;
    logic                out0_valid;
    logic                out0_ready;
    logic signed [WL:0]  out1_real;
    logic signed [WL:0]  out1_imag;
    logic                out1_valid;
    logic                out1_ready;
    logic                lane;
    logic [CNT_W-1:0]    sample_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: the count of samples accepted since the last realign
    // determines lane and position; each lane is a one-entry buffer.
    int          pos;
    logic [WL:0] m_re [2];
    logic [WL:0] m_im [2];
    logic        m_v  [2];

    complex_demux_1to2_15bits #(
        .WL(WL), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sync(sync),
        .in_real(in_real), .in_imag(in_imag),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0_real(out0_real), .out0_imag(out0_imag),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_real(out1_real), .out1_imag(out1_imag),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .lane(lane), .sample_cnt(sample_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic int modelLane();
        return (pos / BLOCK_LEN) % 2;
    endfunction

    function automatic int modelCnt();
        return pos % BLOCK_LEN;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model across
    // the edge, then check every registered output.
    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input logic [WL:0] re, input logic [WL:0] im,
                                 input logic r0, input logic r1);
        logic exp_ready;
        logic acc;
        int   tgt;
        logic rdy [2];
        @(negedge clk);
        rst = r; sync = s; in_valid = v;
        in_real = re; in_imag = im;
        out0_ready = r0; out1_ready = r1;
        rdy[0] = r0; rdy[1] = r1;
        #1;
        tgt = modelLane();
        exp_ready = !r && (!m_v[tgt] || rdy[tgt]);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        @(posedge clk);
        if (r) begin
            pos = 0;
            for (int x = 0; x < 2; x++) begin
                m_re[x] = '0; m_im[x] = '0; m_v[x] = 1'b0;
            end
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (acc && tgt == x) begin
                    m_re[x] = re; m_im[x] = im; m_v[x] = 1'b1;
                end else if (m_v[x] && rdy[x]) begin
                    m_v[x] = 1'b0;
                end
            end
            if (s) pos = 0;
            else if (acc) pos = (pos + 1) % (2 * BLOCK_LEN);
        end
        #1;
        checkOutput("out0_valid", {31'd0, out0_valid}, {31'd0, m_v[0]});
        checkOutput("out1_valid", {31'd0, out1_valid}, {31'd0, m_v[1]});
        checkOutput("out0_real",  {17'd0, out0_real},  {17'd0, m_re[0]});
        checkOutput("out0_imag",  {17'd0, out0_imag},  {17'd0, m_im[0]});
        checkOutput("out1_real",  {17'd0, out1_real},  {17'd0, m_re[1]});
        checkOutput("out1_imag",  {17'd0, out1_imag},  {17'd0, m_im[1]});
        checkOutput("lane",       {31'd0, lane},       32'(modelLane()));
        checkOutput("sample_cnt", {29'd0, sample_cnt}, 32'(modelCnt()));
    endtask

    initial begin
        int guard;
        logic [WL:0] rr;
        logic [WL:0] ri;
        logic [WL:0] xs [5];
        pos = 0;
        for (int x = 0; x < 2; x++) begin
            m_re[x] = '0; m_im[x] = '0; m_v[x] = 1'b0;
        end
        rst = 1'b1; sync = 1'b0; in_valid = 1'b0;
        in_real = '0; in_imag = '0; out0_ready = 1'b0; out1_ready = 1'b0;

        $display("[TB] reset with in_valid high");
        applyStimulus(1, 0, 1, 15'h1234, 15'h0567, 1, 1);
        applyStimulus(1, 0, 1, 15'h1234, 15'h0567, 1, 1);
        applyStimulus(0, 0, 0, 15'h0000, 15'h0000, 1, 1);

        $display("[TB] burst routing");
        for (int k = 0; k < 16; k++)
            applyStimulus(0, 0, 1, 15'(k), 15'(-k), 1, 1);

        $display("[TB] backpressure on lane 0");
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 0, 1, 15'(100 + k), 15'(200 + k), 0, 1);
        for (int k = 0; k < 6; k++)
            applyStimulus(0, 0, 1, 15'(300 + k), 15'(400 + k), 1, 1);

        $display("[TB] sync collision on lane 1");
        guard = 0;
        while (pos != BLOCK_LEN + 5 && guard < 40) begin
            applyStimulus(0, 0, 1, 15'($urandom), 15'($urandom), 1, 1);
            guard++;
        end
        checkOutput("reach_cnt5_lane1", 32'(pos), 32'(BLOCK_LEN + 5));
        applyStimulus(0, 1, 1, 15'h3FFF, 15'h4000, 1, 0);

        $display("[TB] lane 0 streams while lane 1 holds");
        for (int k = 0; k < BLOCK_LEN + 2; k++)
            applyStimulus(0, 0, 1, 15'(500 + k), 15'(600 + k), 1, 0);
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 0, 1, 15'(700 + k), 15'(800 + k), 1, 1);

        $display("[TB] extreme values");
        xs[0] = 15'h4000; xs[1] = 15'h3FFF; xs[2] = 15'h7FFF;
        xs[3] = 15'h0000; xs[4] = 15'h0001;
        for (int k = 0; k < 5; k++)
            applyStimulus(0, 0, 1, xs[k], xs[4 - k], 1, 1);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 300; k++) begin
            rr = 15'($urandom);
            ri = 15'($urandom);
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                          1'($urandom), rr, ri,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
